boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Parametrised SPI-flash-to-RAM boot copier. At power-up, or on a start request, it
//  takes the 6502 bus, wakes the flash, streams LENGTH bytes from FLASH_BASE and writes
//  them to RAM_BASE, then releases the bus and pulses the CPU reset.
//  Adds a programmable SPI clock divider, a re-boot request and a running 16-bit checksum.
// PARAMETERS
//  FLASH_ADDR_BITS  24       flash address width in command, 16 or 24 (other = 24)
//  FLASH_BASE       'h080000 first flash byte address
//  RAM_BASE         'hE000   first RAM address written (19-bit)
//  LENGTH           'h2000   bytes copied, 1..65536
//  SPI_DIV          1        SCK half-period in clocks, >=1
//  WAKE_CYCLES      800      wait after 0xAB release-power-down command
//  RESET_CYCLES     4        cpu_reset_n low time in clocks, >=2
//  AUTOBOOT         1        1 = start copying after reset_n release; 0 = wait for start
// PORTS
//  clock        in   1   system clock
//  reset_n      in   1   async active-low reset
//  start        in   1   one-cycle re-boot request, honoured only in IDLE/DONE
//  flash_so     in   1   SPI MISO
//  flash_si     out  1   SPI MOSI
//  flash_sck    out  1   SPI clock, mode 0
//  flash_cs_n   out  1   SPI chip select
//  address      out  19  RAM write address
//  data         out  8   RAM write data
//  rw           out  1   1 = read/idle, 0 = write strobe
//  bus_drive    out  1   1 = address/data/rw driven by this block (to pad OE)
//  busen        out  1   1 = 6502 bus outputs enabled
//  cpu_reset_n  out  1   6502 RESB
//  booting      out  1   1 while copy in progress (BUS_REQ..CLEANUP)
//  checksum     out  16  sum mod 2^16 of all bytes copied this boot
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; flash_cs_n=1, flash_sck=0, flash_si=0,
//   address=0, data=0, rw=1, bus_drive=0, busen=0, cpu_reset_n=0, booting=0, checksum=0.
//   Reset mid-copy aborts immediately to these values; no partial cleanup.
//  States: IDLE -> BUS_REQ -> WAKE -> WAKE_WAIT -> READ_CMD -> READ_BYTE -> WRITE ->
//   WRITE_END -> (READ_BYTE | CLEANUP) -> CPU_RESET -> DONE.
//  IDLE: leaves on first clock after reset if AUTOBOOT, else on start=1.
//  DONE: start=1 -> BUS_REQ (re-boot); checksum cleared on entry to BUS_REQ.
//  BUS_REQ: busen=0, cpu_reset_n=0, booting=1, bus_drive=1; one cycle.
//  WAKE: cs_n=0, shift 0xAB (8 bits); then cs_n=1 for >=1 clock; WAKE_WAIT counts WAKE_CYCLES.
//  READ_CMD: cs_n=0, shift 0x03 + FLASH_BASE low FLASH_ADDR_BITS bits, MSB first
//   (32 or 24 bits); cs_n stays low through the whole stream.
//  SPI engine: mode 0; sck toggles every SPI_DIV clocks; si updated while sck low
//   before each rising edge; so sampled on each rising edge; byte = 8 rising edges, MSB first.
//  WRITE: address=RAM_BASE+offset (19-bit wrap), data=byte, rw=1 this cycle (setup);
//   WRITE_END: rw=0 for exactly 1 clock, then rw=1 with address/data held one more clock.
//   checksum += byte at WRITE. offset 16-bit, increments after each write.
//  After byte LENGTH-1: CLEANUP: cs_n=1, sck=0, si=0, rw=1, bus_drive=0, busen=1, booting=0.
//  CPU_RESET: cpu_reset_n=0 for RESET_CYCLES clocks, then 1; -> DONE. cpu_reset_n stays
//   low from BUS_REQ through CPU_RESET, so CPU never runs on a partial image.
//  start outside IDLE/DONE is ignored. LENGTH=65536 copies full range, offset wraps to 0 at end only.
//  Address never exceeds 19 bits: RAM_BASE+offset wraps modulo 2^19.
// TESTING
//  1 AUTOBOOT=1, 25AA512 model, FLASH_ADDR_BITS=16, FLASH_BASE='hE000, LENGTH=16, bytes 0x00..0x0F
//    -> RAM 0xE000..0xE00F = 0x00..0x0F, checksum=0x0078, rw low 16 times, each 1 clock.
//  2 FLASH_ADDR_BITS=24, FLASH_BASE='h080000 -> MOSI stream 0x03,0x08,0x00,0x00 after 0xAB wake.
//  3 SPI_DIV=3 -> sck high/low each exactly 3 clocks; data identical to SPI_DIV=1 run.
//  4 Pulse start in DONE with new flash contents -> second copy overwrites RAM, checksum
//    recomputed from 0, cpu_reset_n low again for RESET_CYCLES; start mid-copy -> no effect.
//  5 Assert reset_n=0 during byte 5 -> all outputs at reset values same cycle;
//    release -> fresh boot from offset 0.
//  6 RAM_BASE='h7FFFE, LENGTH=4 -> writes at 0x7FFFE,0x7FFFF,0x00000,0x00001.

Source files
------------

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - SPI-flash-to-RAM boot copier for a 6502 system
// Wakes the flash, streams LENGTH bytes into RAM, then releases the bus and pulses CPU reset.
module boot_loader #(
  parameter int unsigned FLASH_ADDR_BITS = 24,
  parameter logic [23:0] FLASH_BASE      = 24'h080000,
  parameter logic [18:0] RAM_BASE        = 19'h0E000,
  parameter int unsigned LENGTH          = 'h2000,
  parameter int unsigned SPI_DIV         = 1,
  parameter int unsigned WAKE_CYCLES     = 800,
  parameter int unsigned RESET_CYCLES    = 4,
  parameter bit          AUTOBOOT        = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flash_so,
  output logic        flash_si,
  output logic        flash_sck,
  output logic        flash_cs_n,
  output logic [18:0] address,
  output logic [7:0]  data,
  output logic        rw,
  output logic        bus_drive,
  output logic        busen,
  output logic        cpu_reset_n,
  output logic        booting,
  output logic [15:0] checksum
);

  localparam int unsigned CMD_BITS   = (FLASH_ADDR_BITS == 16) ? 24 : 32;
  localparam logic [31:0] READ_WORD  = (FLASH_ADDR_BITS == 16) ?
                                       {8'h03, FLASH_BASE[15:0], 8'h00} : {8'h03, FLASH_BASE};
  localparam logic [15:0] LAST_OFS   = 16'(LENGTH - 1);
  localparam logic [15:0] DIV_LAST   = 16'((SPI_DIV > 1) ? SPI_DIV - 1 : 0);
  localparam logic [19:0] WAKE_LOAD  = 20'((WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 0);
  localparam logic [19:0] RESET_LOAD = 20'((RESET_CYCLES > 1) ? RESET_CYCLES - 1 : 0);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_BUS_REQ   = 4'd1;
  localparam logic [3:0] S_WAKE      = 4'd2;
  localparam logic [3:0] S_WAKE_WAIT = 4'd3;
  localparam logic [3:0] S_READ_CMD  = 4'd4;
  localparam logic [3:0] S_READ_BYTE = 4'd5;
  localparam logic [3:0] S_WRITE     = 4'd6;
  localparam logic [3:0] S_WRITE_END = 4'd7;
  localparam logic [3:0] S_CLEANUP   = 4'd8;
  localparam logic [3:0] S_CPU_RESET = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [30:0] shift_q, shift_d;
  logic [5:0]  bits_q, bits_d;
  logic [15:0] div_q, div_d;
  logic        sck_q, sck_d;
  logic        si_q, si_d;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  rx_q, rx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [15:0] offset_q, offset_d;
  logic        phase_q, phase_d;
  logic [18:0] address_q, address_d;
  logic [7:0]  data_q, data_d;
  logic        rw_q, rw_d;
  logic        bus_drive_q, bus_drive_d;
  logic        busen_q, busen_d;
  logic        cpu_reset_n_q, cpu_reset_n_d;
  logic        booting_q, booting_d;
  logic [15:0] checksum_q, checksum_d;

  logic        spi_active, spi_done, spi_load;
  logic [31:0] spi_word;
  logic [5:0]  spi_bits;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bits_d        = bits_q;
    div_d         = div_q;
    sck_d         = sck_q;
    si_d          = si_q;
    cs_n_d        = cs_n_q;
    rx_d          = rx_q;
    cnt_d         = cnt_q;
    offset_d      = offset_q;
    phase_d       = phase_q;
    address_d     = address_q;
    data_d        = data_q;
    rw_d          = rw_q;
    bus_drive_d   = bus_drive_q;
    busen_d       = busen_q;
    cpu_reset_n_d = cpu_reset_n_q;
    booting_d     = booting_q;
    checksum_d    = checksum_q;
    spi_done      = 1'b0;
    spi_load      = 1'b0;
    spi_word      = '0;
    spi_bits      = '0;

    // Mode-0 engine: bits_q counts rising edges still to come; a byte ends on the fall after the last one.
    spi_active = (state_q == S_WAKE) || (state_q == S_READ_CMD) || (state_q == S_READ_BYTE);
    if (spi_active) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d  = 1'b1;
          rx_d   = {rx_q[6:0], flash_so};
          bits_d = bits_q - 6'd1;
        end else begin
          sck_d = 1'b0;
          if (bits_q == 6'd0) begin
            spi_done = 1'b1;
          end else begin
            si_d    = shift_q[30];
            shift_d = {shift_q[29:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || (state_q == S_IDLE && AUTOBOOT)) begin
          state_d       = S_BUS_REQ;
          checksum_d    = '0;
          offset_d      = '0;
          booting_d     = 1'b1;
          bus_drive_d   = 1'b1;
          busen_d       = 1'b0;
          cpu_reset_n_d = 1'b0;
          rw_d          = 1'b1;
        end
      end
      S_BUS_REQ: begin
        state_d  = S_WAKE;
        cs_n_d   = 1'b0;
        spi_load = 1'b1;
        spi_word = 32'hAB00_0000;
        spi_bits = 6'd8;
      end
      S_WAKE: begin
        if (spi_done) begin
          state_d = S_WAKE_WAIT;
          cs_n_d  = 1'b1;
          si_d    = 1'b0;
          cnt_d   = WAKE_LOAD;
        end
      end
      S_WAKE_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_READ_CMD;
          cs_n_d   = 1'b0;
          spi_load = 1'b1;
          spi_word = READ_WORD;
          spi_bits = 6'(CMD_BITS);
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      S_READ_CMD: begin
        if (spi_done) begin
          state_d  = S_READ_BYTE;
          spi_load = 1'b1;
          spi_bits = 6'd8;
        end
      end
      S_READ_BYTE: begin
        if (spi_done) begin
          state_d   = S_WRITE;
          address_d = RAM_BASE + {3'b000, offset_q};
          data_d    = rx_q;
        end
      end
      S_WRITE: begin
        state_d    = S_WRITE_END;
        checksum_d = checksum_q + {8'h00, data_q};
        rw_d       = 1'b0;
        phase_d    = 1'b0;
      end
      S_WRITE_END: begin
        if (!phase_q) begin
          rw_d    = 1'b1;
          phase_d = 1'b1;
        end else begin
          offset_d = offset_q + 16'd1;
          if (offset_q == LAST_OFS) begin
            state_d     = S_CLEANUP;
            cs_n_d      = 1'b1;
            sck_d       = 1'b0;
            si_d        = 1'b0;
            bus_drive_d = 1'b0;
            busen_d     = 1'b1;
            booting_d   = 1'b0;
          end else begin
            state_d  = S_READ_BYTE;
            spi_load = 1'b1;
            spi_bits = 6'd8;
          end
        end
      end
      S_CLEANUP: begin
        state_d = S_CPU_RESET;
        cnt_d   = RESET_LOAD;
      end
      S_CPU_RESET: begin
        if (cnt_q == '0) begin
          state_d       = S_DONE;
          cpu_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (spi_load) begin
      si_d    = spi_word[31];
      shift_d = spi_word[30:0];
      bits_d  = spi_bits;
      div_d   = '0;
      sck_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bits_q        <= '0;
      div_q         <= '0;
      sck_q         <= 1'b0;
      si_q          <= 1'b0;
      cs_n_q        <= 1'b1;
      rx_q          <= '0;
      cnt_q         <= '0;
      offset_q      <= '0;
      phase_q       <= 1'b0;
      address_q     <= '0;
      data_q        <= '0;
      rw_q          <= 1'b1;
      bus_drive_q   <= 1'b0;
      busen_q       <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      booting_q     <= 1'b0;
      checksum_q    <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bits_q        <= bits_d;
      div_q         <= div_d;
      sck_q         <= sck_d;
      si_q          <= si_d;
      cs_n_q        <= cs_n_d;
      rx_q          <= rx_d;
      cnt_q         <= cnt_d;
      offset_q      <= offset_d;
      phase_q       <= phase_d;
      address_q     <= address_d;
      data_q        <= data_d;
      rw_q          <= rw_d;
      bus_drive_q   <= bus_drive_d;
      busen_q       <= busen_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      booting_q     <= booting_d;
      checksum_q    <= checksum_d;
    end
  end

  assign flash_si    = si_q;
  assign flash_sck   = sck_q;
  assign flash_cs_n  = cs_n_q;
  assign address     = address_q;
  assign data        = data_q;
  assign rw          = rw_q;
  assign bus_drive   = bus_drive_q;
  assign busen       = busen_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign booting     = booting_q;
  assign checksum    = checksum_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader with SPI flash and RAM models
module tb_boot_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a_n, rst_b_n, start_a, start_b;
  logic so_a = 1'b0, so_b = 1'b0;
  logic si_a, sck_a, cs_n_a, rw_a, bus_drive_a, busen_a, cpu_reset_n_a, booting_a;
  logic si_b, sck_b, cs_n_b, rw_b, bus_drive_b, busen_b, cpu_reset_n_b, booting_b;
  logic [18:0] address_a, address_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] checksum_a, checksum_b;

  boot_loader #(.FLASH_ADDR_BITS(16), .FLASH_BASE(24'h00E000), .RAM_BASE(19'h0E000),
                .LENGTH(16), .SPI_DIV(1), .WAKE_CYCLES(20), .RESET_CYCLES(4), .AUTOBOOT(1'b1))
  dut_a (.clock(clock), .reset_n(rst_a_n), .start(start_a), .flash_so(so_a), .flash_si(si_a),
         .flash_sck(sck_a), .flash_cs_n(cs_n_a), .address(address_a), .data(data_a), .rw(rw_a),
         .bus_drive(bus_drive_a), .busen(busen_a), .cpu_reset_n(cpu_reset_n_a),
         .booting(booting_a), .checksum(checksum_a));

  boot_loader #(.FLASH_ADDR_BITS(24), .FLASH_BASE(24'h080000), .RAM_BASE(19'h7FFFE),
                .LENGTH(4), .SPI_DIV(3), .WAKE_CYCLES(10), .RESET_CYCLES(4), .AUTOBOOT(1'b0))
  dut_b (.clock(clock), .reset_n(rst_b_n), .start(start_b), .flash_so(so_b), .flash_si(si_b),
         .flash_sck(sck_b), .flash_cs_n(cs_n_b), .address(address_b), .data(data_b), .rw(rw_b),
         .bus_drive(bus_drive_b), .busen(busen_b), .cpu_reset_n(cpu_reset_n_b),
         .booting(booting_b), .checksum(checksum_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fval(input int g, input int idx);
    return (g != 0) ? 8'(32'hA0 + idx) : 8'(idx);
  endfunction

  // Flash models: shift MOSI in on rising sck, present MISO on falling sck once the read header is in.
  int nb_a, nb_b, k_a, k_b, gen_a = 0;
  logic [31:0] sr_a, sr_b;
  logic [7:0]  cmd_a, cmd_b, fb_a, fb_b;
  logic [15:0] fadr_a;
  logic [23:0] fadr_b;
  logic [7:0]  mosi_a[$], mosi_b[$];

  always @(negedge cs_n_a) nb_a = 0;
  always @(posedge sck_a) if (cs_n_a === 1'b0) begin
    sr_a = {sr_a[30:0], si_a};
    nb_a++;
    if (nb_a % 8 == 0) mosi_a.push_back(sr_a[7:0]);
    if (nb_a == 8) cmd_a = sr_a[7:0];
    if (nb_a == 24) fadr_a = sr_a[15:0];
  end
  always @(negedge sck_a) if (cs_n_a === 1'b0 && cmd_a == 8'h03 && nb_a >= 24) begin
    k_a  = nb_a - 24;
    fb_a = fval(gen_a, int'(fadr_a) - 32'hE000 + k_a / 8);
    so_a = fb_a[7 - (k_a % 8)];
  end

  always @(negedge cs_n_b) nb_b = 0;
  always @(posedge sck_b) if (cs_n_b === 1'b0) begin
    sr_b = {sr_b[30:0], si_b};
    nb_b++;
    if (nb_b % 8 == 0) mosi_b.push_back(sr_b[7:0]);
    if (nb_b == 8) cmd_b = sr_b[7:0];
    if (nb_b == 32) fadr_b = sr_b[23:0];
  end
  always @(negedge sck_b) if (cs_n_b === 1'b0 && cmd_b == 8'h03 && nb_b >= 32) begin
    k_b  = nb_b - 32;
    fb_b = fval(0, int'(fadr_b) - 32'h80000 + k_b / 8);
    so_b = fb_b[7 - (k_b % 8)];
  end

  // RAM models and bus/SCK monitors, sampled mid-cycle
  logic [7:0]  ram_a[logic [18:0]];
  logic [7:0]  ram_b[logic [18:0]];
  logic [18:0] wlog_a[$], wlog_b[$];
  int wr_a = 0, wide_a = 0, run_a = 0, rlow_a = 0;
  int wr_b = 0, wide_b = 0, run_b = 0;
  int srun_b = 0, hi_bad_b = 0, lo_min_b = 1000, rises_b = 0;
  logic sprev_b = 1'b0;

  always @(negedge clock) begin
    if (rw_a === 1'b0 && bus_drive_a === 1'b1) begin
      if (run_a == 0) begin
        ram_a[address_a] = data_a;
        wr_a++;
        wlog_a.push_back(address_a);
      end
      run_a++;
      if (run_a > 1) wide_a++;
    end else run_a = 0;
    if (busen_a === 1'b1 && cpu_reset_n_a === 1'b0) rlow_a++;

    if (rw_b === 1'b0 && bus_drive_b === 1'b1) begin
      if (run_b == 0) begin
        ram_b[address_b] = data_b;
        wr_b++;
        wlog_b.push_back(address_b);
      end
      run_b++;
      if (run_b > 1) wide_b++;
    end else run_b = 0;

    if (cs_n_b === 1'b0) begin
      if (sck_b == sprev_b) srun_b++;
      else begin
        if (sprev_b) begin
          if (srun_b != 3) hi_bad_b++;
        end else begin
          rises_b++;
          if (srun_b < lo_min_b) lo_min_b = srun_b;
        end
        srun_b = 1;
      end
      sprev_b = sck_b;
    end else begin
      srun_b  = 0;
      sprev_b = 1'b0;
    end
  end

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  exp;
  } vec_t;
  vec_t va[16];
  vec_t vb[4];

  task automatic check_reset_a(input string tag);
    check({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
    check({tag, "_sck"}, 32'(sck_a), 32'd0);
    check({tag, "_si"}, 32'(si_a), 32'd0);
    check({tag, "_address"}, 32'(address_a), 32'd0);
    check({tag, "_data"}, 32'(data_a), 32'd0);
    check({tag, "_rw"}, 32'(rw_a), 32'd1);
    check({tag, "_bus_drive"}, 32'(bus_drive_a), 32'd0);
    check({tag, "_busen"}, 32'(busen_a), 32'd0);
    check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n_a), 32'd0);
    check({tag, "_booting"}, 32'(booting_a), 32'd0);
    check({tag, "_checksum"}, 32'(checksum_a), 32'd0);
  endtask

  task automatic wait_done(input bit b, input int bound);
    int c = 0;
    while (((b ? cpu_reset_n_b : cpu_reset_n_a) !== 1'b1) && c < bound) begin
      @(negedge clock);
      c++;
    end
    check(b ? "done_b_in_time" : "done_a_in_time", 32'(c < bound), 32'd1);
  endtask

  task automatic wait_writes_a(input int n, input int bound);
    int c = 0;
    while (wr_a < n && c < bound) begin
      @(negedge clock);
      c++;
    end
    check("writes_a_in_time", 32'(c < bound), 32'd1);
  endtask

  task automatic pulse(input bit b);
    @(negedge clock);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_ram_a(input string tag, input logic [7:0] add);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_ram_%0h", tag, va[i].addr),
            32'(ram_a.exists(va[i].addr) ? ram_a[va[i].addr] : 8'hxx), 32'(va[i].exp + add));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) va[i] = '{19'h0E000 + 19'(i), 8'(i)};
    vb[0] = '{19'h7FFFE, 8'h00};
    vb[1] = '{19'h7FFFF, 8'h01};
    vb[2] = '{19'h00000, 8'h02};
    vb[3] = '{19'h00001, 8'h03};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_a("rst");
    check("rst_b_cs_n", 32'(cs_n_b), 32'd1);
    check("rst_b_rw", 32'(rw_b), 32'd1);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // Autoboot copy of 16 bytes over a 16-bit-address flash
    wait_done(1'b0, 20000);
    check_ram_a("boot1", 8'h00);
    check("boot1_checksum", 32'(checksum_a), 32'h0078);
    check("boot1_writes", 32'(wr_a), 32'd16);
    check("boot1_rw_wide", 32'(wide_a), 32'd0);
    check("boot1_cpu_reset_low", 32'(rlow_a), 32'd5);
    check("boot1_busen", 32'(busen_a), 32'd1);
    check("boot1_bus_drive", 32'(bus_drive_a), 32'd0);
    check("boot1_mosi_len", 32'(mosi_a.size() >= 4), 32'd1);
    if (mosi_a.size() >= 4) begin
      check("boot1_mosi0", 32'(mosi_a[0]), 32'hAB);
      check("boot1_mosi1", 32'(mosi_a[1]), 32'h03);
      check("boot1_mosi2", 32'(mosi_a[2]), 32'hE0);
      check("boot1_mosi3", 32'(mosi_a[3]), 32'h00);
    end
    check("b_idle_cs_n", 32'(cs_n_b), 32'd1);
    check("b_idle_booting", 32'(booting_b), 32'd0);

    // Non-autoboot unit: 24-bit address, divided SCK, RAM address wrap
    pulse(1'b1);
    wait_done(1'b1, 20000);
    check("b_writes", 32'(wr_b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_ram_%0h", vb[i].addr),
            32'(ram_b.exists(vb[i].addr) ? ram_b[vb[i].addr] : 8'hxx), 32'(vb[i].exp));
      if (i < wlog_b.size()) check($sformatf("b_waddr_%0d", i), 32'(wlog_b[i]), 32'(vb[i].addr));
    end
    check("b_checksum", 32'(checksum_b), 32'h0006);
    check("b_mosi_len", 32'(mosi_b.size() >= 5), 32'd1);
    if (mosi_b.size() >= 5) begin
      check("b_mosi0", 32'(mosi_b[0]), 32'hAB);
      check("b_mosi1", 32'(mosi_b[1]), 32'h03);
      check("b_mosi2", 32'(mosi_b[2]), 32'h08);
      check("b_mosi3", 32'(mosi_b[3]), 32'h00);
      check("b_mosi4", 32'(mosi_b[4]), 32'h00);
    end
    check("b_sck_high_bad", 32'(hi_bad_b), 32'd0);
    check("b_sck_low_min", 32'(lo_min_b), 32'd3);
    check("b_sck_rises", 32'(rises_b), 32'd72);
    check("b_rw_wide", 32'(wide_b), 32'd0);

    // Re-boot from DONE with new contents; a start mid-copy must be ignored
    gen_a  = 1;
    wr_a   = 0;
    rlow_a = 0;
    pulse(1'b0);
    @(negedge clock);
    check("reboot_cpu_reset_low", 32'(cpu_reset_n_a), 32'd0);
    check("reboot_booting", 32'(booting_a), 32'd1);
    check("reboot_checksum_clr", 32'(checksum_a), 32'd0);
    wait_writes_a(3, 20000);
    pulse(1'b0);
    wait_done(1'b0, 20000);
    check_ram_a("boot2", 8'hA0);
    check("boot2_checksum", 32'(checksum_a), 32'h0A78);
    check("boot2_writes", 32'(wr_a), 32'd16);
    check("boot2_cpu_reset_low", 32'(rlow_a), 32'd5);

    // Reset in the middle of byte 5 aborts at once; release gives a fresh boot from offset 0
    gen_a = 0;
    wr_a  = 0;
    pulse(1'b0);
    wait_writes_a(5, 20000);
    repeat (2) @(negedge clock);
    #2 rst_a_n = 1'b0;
    #1 check_reset_a("abort");
    @(negedge clock);
    wlog_a.delete();
    wr_a    = 0;
    rst_a_n = 1'b1;
    wait_done(1'b0, 20000);
    check("fresh_first_addr", 32'(wlog_a.size() > 0 ? wlog_a[0] : 19'h7FFFF), 32'h0E000);
    check("fresh_writes", 32'(wr_a), 32'd16);
    check("fresh_checksum", 32'(checksum_a), 32'h0078);
    check_ram_a("fresh", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
